// File: rtl/hilo_div_unit.sv
// HI/LO register file with MTHI/MTLO writes and a WIDTH-step restoring divider (DIV/DIVU).
// Divide result lands WIDTH+1 edges after start; stall holds upstream from start request until DONE.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             start_div,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  output logic             stall,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [5:0]       r_count;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_rem, r_dvd, r_dvs;
  logic             r_qsign, r_rsign;

  logic             w_start, w_sa, w_sb, w_ge;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_rem_nx, w_quot_fin, w_rem_fin;
  logic [WIDTH:0]   w_shift, w_diff;

  assign w_start = (r_state == S_IDLE) && start_div && !cancel;
  assign w_sa    = div_signed & opa[WIDTH-1];
  assign w_sb    = div_signed & opb[WIDTH-1];
  assign w_abs_a = w_sa ? -opa : opa;
  assign w_abs_b = w_sb ? -opb : opb;

  // Partial remainder is one bit wider after the shift, so compare at WIDTH+1 bits.
  assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

  assign w_quot_fin = r_qsign ? -r_dvd : r_dvd;
  assign w_rem_fin  = r_rsign ? -r_rem : r_rem;

  assign stall = w_start || (r_state == S_BUSY);
  assign hi_o  = r_hi;
  assign lo_o  = r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nx = (opb == '0) ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (cancel)                           w_state_nx = S_IDLE;
        else if (r_count == 6'(WIDTH - 1))    w_state_nx = S_DONE;
      end
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hilo_we[1]) r_hi <= wdata;
          if (hilo_we[0]) r_lo <= wdata;
          if (w_start) begin
            r_count <= '0;
            r_dvs   <= w_abs_b;
            if (opb == '0) begin
              // Divide by zero skips iteration and reports raw values unsigned.
              r_dvd   <= '1;
              r_rem   <= opa;
              r_qsign <= 1'b0;
              r_rsign <= 1'b0;
            end else begin
              r_dvd   <= w_abs_a;
              r_rem   <= '0;
              r_qsign <= w_sa ^ w_sb;
              r_rsign <= w_sa;
            end
          end
        end
        S_BUSY: begin
          if (!cancel) begin
            r_rem   <= w_rem_nx;
            r_dvd   <= {r_dvd[WIDTH-2:0], w_ge};
            r_count <= r_count + 6'd1;
          end
        end
        S_DONE: begin
          if (!cancel) begin
            r_hi <= w_rem_fin;
            r_lo <= w_quot_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed plus randomized checks of hilo_div_unit against an arithmetic reference model.
module tb_hilo_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  hilo_we = 2'b00;
  logic [31:0] wdata = '0;
  logic        start_div = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        cancel = 1'b0;
  logic        stall;
  logic [31:0] hi_o, lo_o;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .hilo_we(hilo_we), .wdata(wdata),
    .start_div(start_div), .div_signed(div_signed), .opa(opa), .opb(opb),
    .cancel(cancel), .stall(stall), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (sg) begin
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic mt(input logic [1:0] we, input logic [31:0] d);
    @(negedge clk);
    hilo_we = we;
    wdata   = d;
    @(negedge clk);
    hilo_we = 2'b00;
    if (we[1]) m_hi = d;
    if (we[0]) m_lo = d;
    chk("mt_hi", hi_o, m_hi);
    chk("mt_lo", lo_o, m_lo);
  endtask

  // cancel_at: stall-cycle index at which cancel is raised (0 = never); poke issues MTHI/MTLO while busy.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input int cancel_at, input bit poke);
    int          ncyc;
    logic [31:0] q, r;
    @(negedge clk);
    start_div  = 1'b1;
    div_signed = sg;
    opa        = a;
    opb        = b;
    #1;
    ncyc = 0;
    while (stall === 1'b1 && ncyc < 100) begin
      ncyc++;
      @(negedge clk);
      hilo_we = 2'b00;
      cancel  = 1'b0;
      if (poke && ncyc == 4) begin
        chk("busy_we_hi", hi_o, m_hi);
        chk("busy_we_lo", lo_o, m_lo);
      end
      if (poke && ncyc == 3) begin
        hilo_we = 2'b11;
        wdata   = $urandom;
      end
      if (cancel_at == ncyc) begin
        cancel    = 1'b1;
        start_div = 1'b0;
      end
      #1;
    end
    start_div = 1'b0;
    hilo_we   = 2'b00;
    cancel    = 1'b0;
    if (cancel_at != 0) begin
      chk("cancel_cycles", 32'(ncyc), 32'(cancel_at + 1));
      @(negedge clk);
      chk("cancel_hi", hi_o, m_hi);
      chk("cancel_lo", lo_o, m_lo);
      chk("cancel_stall", {31'd0, stall}, 32'd0);
    end else begin
      chk("stall_cycles", 32'(ncyc), (b == 32'd0) ? 32'd1 : 32'd33);
      chk("done_hold_hi", hi_o, m_hi);
      @(negedge clk);
      ref_div(a, b, sg, q, r);
      m_hi = r;
      m_lo = q;
      chk("div_hi", hi_o, m_hi);
      chk("div_lo", lo_o, m_lo);
      chk("div_stall", {31'd0, stall}, 32'd0);
    end
  endtask

  initial begin
    #1;
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mt(2'b10, 32'hA5A5A5A5);
    mt(2'b01, 32'h5A5A5A5A);
    mt(2'b11, 32'h0BADF00D);

    run_div(32'd100, 32'd7, 1'b0, 0, 1'b0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, 1'b0);
    run_div(32'd5, 32'd0, 1'b0, 0, 1'b0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 0, 1'b0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 0, 1'b0);
    run_div(32'd12345, 32'd99, 1'b0, 0, 1'b1);

    mt(2'b11, 32'h00001234);
    run_div(32'd1000, 32'd3, 1'b0, 5, 1'b0);
    @(negedge clk);
    run_div(32'd1000, 32'd3, 1'b0, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 17);
        2:       b = -$urandom_range(1, 17);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) mt(2'($urandom_range(1, 3)), $urandom);
      run_div(a, b, 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    // Asynchronous reset while the divider is mid-flight.
    @(negedge clk);
    start_div  = 1'b1;
    div_signed = 1'b0;
    opa        = 32'd999;
    opb        = 32'd4;
    repeat (10) @(negedge clk);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    start_div = 1'b0;
    rst_n     = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mt(2'b10, 32'hCAFEBABE);
    run_div(32'd81, 32'd9, 1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
